// File: rtl/minibyte_ctrl_if.sv
// Control bundle between the minibyte sequencer (master) and the datapath (slave).
// Carries the memory read bus, the branch condition inputs and every control strobe.
interface minibyte_ctrl_if;
  logic [7:0] data_in;
  logic       br_zero_in;
  logic       br_negative_in;
  logic       ctrl_set_a_out;
  logic       ctrl_set_m_out;
  logic       ctrl_set_pc_out;
  logic       ctrl_inc_pc_out;
  logic       ctrl_addr_mux_out;
  logic [2:0] ctrl_alu_op_out;
  logic       ctrl_we_out;
  logic       halted_out;

  modport master (
    input  data_in, br_zero_in, br_negative_in,
    output ctrl_set_a_out, ctrl_set_m_out, ctrl_set_pc_out, ctrl_inc_pc_out,
           ctrl_addr_mux_out, ctrl_alu_op_out, ctrl_we_out, halted_out
  );

  modport slave (
    output data_in, br_zero_in, br_negative_in,
    input  ctrl_set_a_out, ctrl_set_m_out, ctrl_set_pc_out, ctrl_inc_pc_out,
           ctrl_addr_mux_out, ctrl_alu_op_out, ctrl_we_out, halted_out
  );
endinterface

// File: rtl/minibyte_ctrl.sv
// minibyte instruction sequencer: FETCH/EXEC/HALT FSM, opcode decode and Z/N flags.
// All strobes are combinational from state, opcode and flags; reset forces them low.
module minibyte_ctrl (
  input  logic                 clk_in,
  input  logic                 rst_in,
  minibyte_ctrl_if.master      bus
);

  localparam logic [1:0] ST_FETCH = 2'b00;
  localparam logic [1:0] ST_EXEC  = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDM = 4'h2;
  localparam logic [3:0] OP_LDA = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_BZ  = 4'hB;
  localparam logic [3:0] OP_BN  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_OR     = 3'b100;
  localparam logic [2:0] ALU_XOR    = 3'b101;
  localparam logic [2:0] ALU_PASS_A = 3'b110;

  logic [1:0] state, state_next;
  // Low nibble of the instruction byte is never decoded, so only the opcode field is held.
  logic [3:0] ir_op;
  logic       z_flag, n_flag;

  logic       set_a, set_m, set_pc, inc_pc, addr_mux, we, halted;
  logic [2:0] alu_op;

  always_comb begin
    set_a    = 1'b0;
    set_m    = 1'b0;
    set_pc   = 1'b0;
    inc_pc   = 1'b0;
    addr_mux = 1'b0;
    alu_op   = ALU_PASS_B;
    we       = 1'b0;
    halted   = 1'b0;
    if (!rst_in) begin
      case (state)
        ST_FETCH: inc_pc = 1'b1;
        ST_EXEC: begin
          case (ir_op)
            OP_LDI: begin set_a = 1'b1; inc_pc = 1'b1; end
            OP_LDM: begin set_m = 1'b1; inc_pc = 1'b1; end
            OP_LDA: begin addr_mux = 1'b1; set_a = 1'b1; end
            OP_STA: begin addr_mux = 1'b1; alu_op = ALU_PASS_A; we = 1'b1; end
            OP_ADD: begin addr_mux = 1'b1; alu_op = ALU_ADD; set_a = 1'b1; end
            OP_SUB: begin addr_mux = 1'b1; alu_op = ALU_SUB; set_a = 1'b1; end
            OP_AND: begin addr_mux = 1'b1; alu_op = ALU_AND; set_a = 1'b1; end
            OP_OR:  begin addr_mux = 1'b1; alu_op = ALU_OR;  set_a = 1'b1; end
            OP_XOR: begin addr_mux = 1'b1; alu_op = ALU_XOR; set_a = 1'b1; end
            OP_JMP: set_pc = 1'b1;
            OP_BZ: begin
              set_pc = z_flag;
              inc_pc = !z_flag;
            end
            OP_BN: begin
              set_pc = n_flag;
              inc_pc = !n_flag;
            end
            default: ; // NOP, reserved 0xD/0xE and HLT drive no strobes
          endcase
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = ST_FETCH;
    case (state)
      ST_FETCH: state_next = ST_EXEC;
      ST_EXEC:  state_next = (ir_op == OP_HLT) ? ST_HALT : ST_FETCH;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= ST_FETCH;
      ir_op  <= OP_NOP;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH)
        ir_op <= bus.data_in[7:4];
      if (set_a) begin
        z_flag <= bus.br_zero_in;
        n_flag <= bus.br_negative_in;
      end
    end
  end

  assign bus.ctrl_set_a_out    = set_a;
  assign bus.ctrl_set_m_out    = set_m;
  assign bus.ctrl_set_pc_out   = set_pc;
  assign bus.ctrl_inc_pc_out   = inc_pc;
  assign bus.ctrl_addr_mux_out = addr_mux;
  assign bus.ctrl_alu_op_out   = alu_op;
  assign bus.ctrl_we_out       = we;
  assign bus.halted_out        = halted;

endmodule

// File: tb/tb_minibyte_ctrl.sv
// Scoreboard bench for minibyte_ctrl: each driven cycle queues the expected strobe
// vector {halted, we, alu_op, addr_mux, inc_pc, set_pc, set_m, set_a}, checked at negedge.
module tb_minibyte_ctrl;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  minibyte_ctrl_if bus ();

  minibyte_ctrl dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [9:0] mk(input logic h, input logic w, input logic [2:0] alu,
                                    input logic m, input logic i, input logic sp,
                                    input logic sm, input logic sa);
    return {h, w, alu, m, i, sp, sm, sa};
  endfunction

  localparam logic [9:0] E_ZERO  = 10'd0;
  localparam logic [9:0] E_FETCH = mk(0, 0, 3'b000, 0, 1, 0, 0, 0);
  localparam logic [9:0] E_HALT  = mk(1, 0, 3'b000, 0, 0, 0, 0, 0);
  localparam logic [9:0] E_LDI   = mk(0, 0, 3'b000, 0, 1, 0, 0, 1);
  localparam logic [9:0] E_LDM   = mk(0, 0, 3'b000, 0, 1, 0, 1, 0);
  localparam logic [9:0] E_LDA   = mk(0, 0, 3'b000, 1, 0, 0, 0, 1);
  localparam logic [9:0] E_STA   = mk(0, 1, 3'b110, 1, 0, 0, 0, 0);
  localparam logic [9:0] E_ADD   = mk(0, 0, 3'b001, 1, 0, 0, 0, 1);
  localparam logic [9:0] E_SUB   = mk(0, 0, 3'b010, 1, 0, 0, 0, 1);
  localparam logic [9:0] E_AND   = mk(0, 0, 3'b011, 1, 0, 0, 0, 1);
  localparam logic [9:0] E_OR    = mk(0, 0, 3'b100, 1, 0, 0, 0, 1);
  localparam logic [9:0] E_XOR   = mk(0, 0, 3'b101, 1, 0, 0, 0, 1);
  localparam logic [9:0] E_TAKEN = mk(0, 0, 3'b000, 0, 0, 1, 0, 0);
  localparam logic [9:0] E_NTAKE = mk(0, 0, 3'b000, 0, 1, 0, 0, 0);

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t cur;
  int  errors = 0;
  int  checks = 0;

  logic [9:0] obs;
  assign obs = {bus.halted_out, bus.ctrl_we_out, bus.ctrl_alu_op_out, bus.ctrl_addr_mux_out,
                bus.ctrl_inc_pc_out, bus.ctrl_set_pc_out, bus.ctrl_set_m_out, bus.ctrl_set_a_out};

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check_eq(cur.tag, obs, cur.exp);
    end
  end

  // Drive one cycle of inputs and queue what the outputs must be during that cycle.
  task automatic cyc(input logic r, input logic [7:0] d, input logic z, input logic n,
                     input logic [9:0] e, input string tag);
    sb_t item;
    rst_in             = r;
    bus.data_in        = d;
    bus.br_zero_in     = z;
    bus.br_negative_in = n;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
    @(posedge clk_in);
    #1;
  endtask

  typedef struct {
    logic [7:0] code;
    logic [9:0] exp;
    string      tag;
  } op_t;

  op_t ops[$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.data_in        = 8'hF0;
    bus.br_zero_in     = 1'b0;
    bus.br_negative_in = 1'b0;
    @(posedge clk_in);
    #1;

    // Reset held two cycles, then HLT fetched straight out of reset
    cyc(1, 8'hF0, 0, 0, E_ZERO,  "rst_c0");
    cyc(1, 8'hF0, 0, 0, E_ZERO,  "rst_c1");
    cyc(0, 8'hF0, 0, 0, E_FETCH, "post_rst_fetch");
    cyc(0, 8'hF0, 0, 0, E_ZERO,  "hlt_exec");
    cyc(0, 8'hF0, 0, 0, E_HALT,  "halted");
    cyc(1, 8'h10, 0, 0, E_ZERO,  "rst_from_halt");

    // LDI with Z=1, then taken BZ
    cyc(0, 8'h10, 0, 0, E_FETCH, "ldi_fetch");
    cyc(0, 8'h00, 1, 0, E_LDI,   "ldi_exec");
    cyc(0, 8'hB0, 0, 0, E_FETCH, "bz_fetch");
    cyc(0, 8'h42, 0, 0, E_TAKEN, "bz_taken");

    // LDI with Z=0,N=1; BZ falls through, STA keeps flags, BN taken
    cyc(0, 8'h10, 0, 0, E_FETCH, "ldi2_fetch");
    cyc(0, 8'h00, 0, 1, E_LDI,   "ldi2_exec");
    cyc(0, 8'hB0, 1, 0, E_FETCH, "bz2_fetch");
    cyc(0, 8'h42, 1, 0, E_NTAKE, "bz_not_taken");
    cyc(0, 8'h4F, 1, 0, E_FETCH, "sta_fetch");
    cyc(0, 8'h00, 1, 0, E_STA,   "sta_exec");
    cyc(0, 8'hC0, 1, 0, E_FETCH, "bn_fetch");
    cyc(0, 8'h55, 1, 0, E_TAKEN, "bn_taken_after_sta");
    cyc(0, 8'hB0, 1, 0, E_FETCH, "bz3_fetch");
    cyc(0, 8'h55, 1, 0, E_NTAKE, "bz_still_not_taken");

    // STA then ADD; ADD loads Z=1,N=0
    cyc(0, 8'h4F, 0, 0, E_FETCH, "sta2_fetch");
    cyc(0, 8'h00, 0, 0, E_STA,   "sta2_exec");
    cyc(0, 8'h53, 0, 0, E_FETCH, "add_fetch");
    cyc(0, 8'h00, 1, 0, E_ADD,   "add_exec");
    cyc(0, 8'hB0, 0, 1, E_FETCH, "bz4_fetch");
    cyc(0, 8'h00, 0, 1, E_TAKEN, "bz_after_add");
    cyc(0, 8'hC0, 0, 1, E_FETCH, "bn2_fetch");
    cyc(0, 8'h00, 0, 1, E_NTAKE, "bn_after_add");

    // Remaining opcodes; set_a ops leave Z=N=1 behind
    ops.push_back('{8'h05, E_ZERO, "nop"});
    ops.push_back('{8'h2A, E_LDM,  "ldm"});
    ops.push_back('{8'h30, E_LDA,  "lda"});
    ops.push_back('{8'h60, E_SUB,  "sub"});
    ops.push_back('{8'h7F, E_AND,  "and"});
    ops.push_back('{8'h81, E_OR,   "or"});
    ops.push_back('{8'h9C, E_XOR,  "xor"});
    ops.push_back('{8'hA3, E_TAKEN, "jmp"});
    ops.push_back('{8'hD7, E_ZERO, "rsv_d7"});
    ops.push_back('{8'hE0, E_ZERO, "rsv_e0"});
    foreach (ops[k]) begin
      cyc(0, ops[k].code, 0, 0, E_FETCH, {ops[k].tag, "_fetch"});
      cyc(0, 8'hFF, 1, 1, ops[k].exp, {ops[k].tag, "_exec"});
    end
    cyc(0, 8'hB0, 0, 0, E_FETCH, "bz5_fetch");
    cyc(0, 8'h00, 0, 0, E_TAKEN, "bz_after_xor");
    cyc(0, 8'hC0, 0, 0, E_FETCH, "bn3_fetch");
    cyc(0, 8'h00, 0, 0, E_TAKEN, "bn_after_xor");

    // HLT and a long halt with toggling inputs
    cyc(0, 8'hF3, 0, 0, E_FETCH, "hlt2_fetch");
    cyc(0, 8'h4F, 0, 0, E_ZERO,  "hlt2_exec");
    for (int unsigned i = 0; i < 22; i++)
      cyc(0, 8'(i * 37 + 1), i[0], i[1], E_HALT, "halt_hold");

    // Reset clears flags: both branches fall through
    cyc(1, 8'hB0, 1, 1, E_ZERO,  "rst_halt2");
    cyc(0, 8'hB0, 0, 0, E_FETCH, "bz6_fetch");
    cyc(0, 8'h00, 0, 0, E_NTAKE, "bz_after_rst");
    cyc(0, 8'hC0, 0, 0, E_FETCH, "bn4_fetch");
    cyc(0, 8'h00, 0, 0, E_NTAKE, "bn_after_rst");

    // Reset in the EXEC cycle of STA suppresses we
    cyc(0, 8'h4F, 0, 0, E_FETCH, "sta3_fetch");
    cyc(1, 8'h00, 0, 0, E_ZERO,  "sta_exec_rst");
    cyc(0, 8'h00, 0, 0, E_FETCH, "resume_fetch");
    cyc(0, 8'h00, 0, 0, E_ZERO,  "resume_nop");

    check_eq("sb_drain", 10'(sb.size()), 10'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
